mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single RI5CY-protocol data memory port between the trace-assisted cache miss path (master 0) and a second requester (master 1, trace/fill or instruction side). It sits between the cache's `cache_mem_data_*` outputs and the memory. It adds zero cycles of latency on the request and response paths. It tracks outstanding transactions in an ordered ID queue so each `rvalid` returns to the master that was granted.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_id_fifo.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-master memory port arbiter.
// Master IDs are single bits so the outstanding-transaction queue stays narrow.
package mem_arb_pkg;

  typedef logic master_id_t;

  localparam master_id_t M_CACHE = 1'b0;
  localparam master_id_t M_AUX   = 1'b1;

  // Width of a counter that must hold every value from 0 to depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Circular FIFO of master IDs for transactions that were granted but not yet answered.
// Push and pop may happen in the same cycle, including when the FIFO is full.
module arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  master_id_t                    push_id,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output master_id_t                    head,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = count_width(DEPTH);

  master_id_t       slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RI5CY-style data memory port between the cache miss path and an auxiliary
// requester, with zero added latency and in-order routing of responses back to their owners.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o
);

  localparam int CNT_W = count_width(MAX_OUTSTANDING);

  logic             locked;
  master_id_t       sel;
  master_id_t       last;
  logic             err;

  master_id_t       winner;
  master_id_t       select;
  logic             req_active;
  logic             room;
  logic             push;
  logic             pop;
  logic             id_full;
  logic             id_empty;
  master_id_t       id_head;
  logic [CNT_W-1:0] id_count;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (select),
    .pop     (pop),
    .full    (id_full),
    .empty   (id_empty),
    .head    (id_head),
    .count   (id_count)
  );

  // A response retiring this cycle makes room for a request in the same cycle
  assign pop  = mem_rvalid_i && !id_empty;
  assign room = !id_full || pop;

  assign winner = (m0_req_i && m1_req_i) ? ~last : (m0_req_i ? M_CACHE : M_AUX);

  // A locked request keeps the bus even when the queue is full: it was admitted with room
  always_comb begin
    select     = winner;
    req_active = 1'b0;
    if (locked) begin
      select     = sel;
      req_active = 1'b1;
    end else if ((m0_req_i || m1_req_i) && room) begin
      req_active = 1'b1;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (req_active) begin
      if (select == M_AUX) begin
        mem_addr_o  = m1_addr_i;
        mem_we_o    = m1_we_i;
        mem_be_o    = m1_be_i;
        mem_wdata_o = m1_wdata_i;
      end else begin
        mem_addr_o  = m0_addr_i;
        mem_we_o    = m0_we_i;
        mem_be_o    = m0_be_i;
        mem_wdata_o = m0_wdata_i;
      end
    end
  end

  assign mem_req_o = req_active;
  assign push      = req_active && mem_gnt_i;
  assign m0_gnt_o  = push && (select == M_CACHE);
  assign m1_gnt_o  = push && (select == M_AUX);

  assign m0_rvalid_o = pop && (id_head == M_CACHE);
  assign m1_rvalid_o = pop && (id_head == M_AUX);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
  assign err_o       = err;

  // last starts at M_AUX so the cache side wins the first contention after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
      sel    <= M_CACHE;
      last   <= M_AUX;
      err    <= 1'b0;
    end else begin
      if (push) begin
        locked <= 1'b0;
        last   <= select;
      end else if (req_active) begin
        locked <= 1'b1;
        sel    <= select;
      end
      if (mem_rvalid_i && (id_count == '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter: per-cycle vectors plus a response-order scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [BW-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  logic [AW-1:0] addr0  = 16'h0040;
  logic [AW-1:0] addr1  = 16'h0080;
  logic [BW-1:0] be0    = 4'hF;
  logic [BW-1:0] be1    = 4'h3;
  logic [DW-1:0] wdata0 = 32'h1111_1111;
  logic [DW-1:0] wdata1 = 32'h2222_2222;

  typedef struct {
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic          gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          e_g0, e_g1, e_req;
    master_id_t    e_sel;
    logic          e_rv0, e_rv1, e_err;
  } vec_t;

  vec_t       vecs[$];
  master_id_t sbq[$];
  int         nVectors    = 0;
  int         nMiscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_i     (m0_req_i),
    .m0_addr_i    (m0_addr_i),
    .m0_we_i      (m0_we_i),
    .m0_be_i      (m0_be_i),
    .m0_wdata_i   (m0_wdata_i),
    .m0_gnt_o     (m0_gnt_o),
    .m0_rvalid_o  (m0_rvalid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m1_req_i     (m1_req_i),
    .m1_addr_i    (m1_addr_i),
    .m1_we_i      (m1_we_i),
    .m1_be_i      (m1_be_i),
    .m1_wdata_i   (m1_wdata_i),
    .m1_gnt_o     (m1_gnt_o),
    .m1_rvalid_o  (m1_rvalid_o),
    .m1_rdata_o   (m1_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  task automatic addVec(input logic rst, m0r, m0w, m1r, m1w, gnt, rv,
                        input logic [DW-1:0] rd,
                        input logic eg0, eg1, ereq, input master_id_t esel,
                        input logic erv0, erv1, eerr);
    vec_t v;
    v.rst = rst; v.m0_req = m0r; v.m0_we = m0w; v.m1_req = m1r; v.m1_we = m1w;
    v.gnt = gnt; v.rvalid = rv; v.rdata = rd;
    v.e_g0 = eg0; v.e_g1 = eg1; v.e_req = ereq; v.e_sel = esel;
    v.e_rv0 = erv0; v.e_rv1 = erv1; v.e_err = eerr;
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs and records which master the bench expects to be granted
  task automatic applyStimulus(input vec_t v);
    rst_n        = !v.rst;
    m0_req_i     = v.m0_req;
    m0_we_i      = v.m0_we;
    m0_addr_i    = addr0;
    m0_be_i      = be0;
    m0_wdata_i   = wdata0;
    m1_req_i     = v.m1_req;
    m1_we_i      = v.m1_we;
    m1_addr_i    = addr1;
    m1_be_i      = be1;
    m1_wdata_i   = wdata1;
    mem_gnt_i    = v.gnt;
    mem_rvalid_i = v.rvalid;
    mem_rdata_i  = v.rdata;
    if (v.rst) sbq.delete();
    if (v.e_g0) sbq.push_back(M_CACHE);
    if (v.e_g1) sbq.push_back(M_AUX);
  endtask

  task automatic cmp(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Compares all outputs against the vector and checks response routing against the scoreboard
  task automatic checkOutput(input vec_t v, input int idx);
    logic [AW-1:0] eAddr;
    logic          eWe;
    logic [BW-1:0] eBe;
    logic [DW-1:0] eWd;
    master_id_t    expId;
    eAddr = '0; eWe = 1'b0; eBe = '0; eWd = '0;
    if (v.e_req) begin
      eAddr = (v.e_sel == M_AUX) ? addr1  : addr0;
      eWe   = (v.e_sel == M_AUX) ? v.m1_we : v.m0_we;
      eBe   = (v.e_sel == M_AUX) ? be1    : be0;
      eWd   = (v.e_sel == M_AUX) ? wdata1 : wdata0;
    end
    nVectors++;
    cmp("m0_gnt",    idx, 64'(m0_gnt_o),    64'(v.e_g0));
    cmp("m1_gnt",    idx, 64'(m1_gnt_o),    64'(v.e_g1));
    cmp("mem_req",   idx, 64'(mem_req_o),   64'(v.e_req));
    cmp("mem_addr",  idx, 64'(mem_addr_o),  64'(eAddr));
    cmp("mem_we",    idx, 64'(mem_we_o),    64'(eWe));
    cmp("mem_be",    idx, 64'(mem_be_o),    64'(eBe));
    cmp("mem_wdata", idx, 64'(mem_wdata_o), 64'(eWd));
    cmp("m0_rvalid", idx, 64'(m0_rvalid_o), 64'(v.e_rv0));
    cmp("m1_rvalid", idx, 64'(m1_rvalid_o), 64'(v.e_rv1));
    cmp("m0_rdata",  idx, 64'(m0_rdata_o),  v.e_rv0 ? 64'(v.rdata) : 64'd0);
    cmp("m1_rdata",  idx, 64'(m1_rdata_o),  v.e_rv1 ? 64'(v.rdata) : 64'd0);
    cmp("err",       idx, 64'(err_o),       64'(v.e_err));
    if (m0_rvalid_o || m1_rvalid_o) begin
      if (sbq.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL scoreboard vec %0d: got rvalid for master %0d expected none outstanding",
                 idx, m1_rvalid_o);
      end else begin
        expId = sbq.pop_front();
        cmp("rsp_owner", idx, 64'(m1_rvalid_o), 64'(expId));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_be_i = '0; m1_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

    //     rst m0r m0w m1r m1w gnt rv rdata          eg0 eg1 ereq esel     erv0 erv1 err
    addVec(1, 0, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);
    // single read
    addVec(0, 1, 0, 0, 0, 1, 0, 32'h0,           1, 0, 1, M_CACHE, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,    0, 0, 0, M_CACHE, 1, 0, 0);
    // contention with responses returning in grant order
    addVec(1, 0, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);
    addVec(0, 1, 0, 1, 0, 1, 0, 32'h0,           1, 0, 1, M_CACHE, 0, 0, 0);
    addVec(0, 1, 0, 1, 0, 1, 1, 32'hA000_0001,   0, 1, 1, M_AUX,   1, 0, 0);
    addVec(0, 1, 0, 1, 0, 1, 1, 32'hA000_0002,   1, 0, 1, M_CACHE, 0, 1, 0);
    addVec(0, 1, 0, 1, 0, 1, 1, 32'hA000_0003,   0, 1, 1, M_AUX,   1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'hA000_0004,   0, 0, 0, M_CACHE, 0, 1, 0);
    // stall lock on m1 while m0 also requests
    addVec(0, 0, 0, 1, 1, 0, 0, 32'h0,           0, 0, 1, M_AUX,   0, 0, 0);
    addVec(0, 1, 0, 1, 1, 0, 0, 32'h0,           0, 0, 1, M_AUX,   0, 0, 0);
    addVec(0, 1, 0, 1, 1, 0, 0, 32'h0,           0, 0, 1, M_AUX,   0, 0, 0);
    addVec(0, 1, 0, 1, 1, 1, 0, 32'h0,           0, 1, 1, M_AUX,   0, 0, 0);
    addVec(0, 1, 1, 0, 0, 1, 0, 32'h0,           1, 0, 1, M_CACHE, 0, 0, 0);
    // queue full, then push and pop together
    addVec(0, 1, 0, 0, 0, 1, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 1, 1, 32'hB000_0001,   1, 0, 1, M_CACHE, 0, 1, 0);
    addVec(0, 1, 0, 0, 0, 1, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'hB000_0002,   0, 0, 0, M_CACHE, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'hB000_0003,   0, 0, 0, M_CACHE, 1, 0, 0);
    // reset with one outstanding, then orphan response
    addVec(0, 0, 0, 1, 1, 1, 0, 32'h0,           0, 1, 1, M_AUX,   0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'h0000_0055,   0, 0, 0, M_CACHE, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 1);
    addVec(0, 1, 0, 0, 0, 1, 0, 32'h0,           1, 0, 1, M_CACHE, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'hB000_0004,   0, 0, 0, M_CACHE, 1, 0, 1);
    addVec(1, 0, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, M_CACHE, 0, 0, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end

    // sustained contention with a response every cycle: grants alternate from m0
    for (int i = 0; i <= 8; i++) begin
      vec_t v;
      logic [DW-1:0] rd;
      rd = 32'hC000_0000 + DW'(i);
      v.rst = 1'b0; v.m0_we = 1'b0; v.m1_we = 1'b0;
      v.m0_req = (i < 8); v.m1_req = (i < 8); v.gnt = (i < 8);
      v.rvalid = (i > 0); v.rdata = rd;
      v.e_req = (i < 8);
      v.e_sel = master_id_t'(i % 2);
      v.e_g0  = (i < 8) && (i % 2 == 0);
      v.e_g1  = (i < 8) && (i % 2 == 1);
      v.e_rv0 = (i > 0) && ((i - 1) % 2 == 0);
      v.e_rv1 = (i > 0) && ((i - 1) % 2 == 1);
      v.e_err = 1'b0;
      @(posedge clk);
      #1 applyStimulus(v);
      @(negedge clk);
      checkOutput(v, 100 + i);
    end

    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
